// File: rtl/uart_alu_sequencer_if.sv
// Handshake bundle between the command sequencer and its uart_rx, ALU and uart_tx neighbours.
// The sequencer connects through the slave modport; the surrounding UART top uses master.
interface uart_alu_sequencer_if #(
    parameter int DBIT   = 8,
    parameter int OP_BIT = 6
);
    logic              rx_done_tick;
    logic [DBIT-1:0]   rx_data;
    logic              tx_done_tick;
    logic [DBIT-1:0]   alu_result;
    logic [DBIT-1:0]   alu_a;
    logic [DBIT-1:0]   alu_b;
    logic [OP_BIT-1:0] alu_op;
    logic              tx_start;
    logic [DBIT-1:0]   tx_data;
    logic              busy;
    logic              overrun;
    logic              timeout;

    modport slave (
        input  rx_done_tick,
        input  rx_data,
        input  tx_done_tick,
        input  alu_result,
        output alu_a,
        output alu_b,
        output alu_op,
        output tx_start,
        output tx_data,
        output busy,
        output overrun,
        output timeout
    );

    modport master (
        output rx_done_tick,
        output rx_data,
        output tx_done_tick,
        output alu_result,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  overrun,
        input  timeout
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects an A/B/opcode frame from uart_rx, drives the external ALU and returns its
// result through uart_tx, waiting for the stop bit before accepting the next frame.
module uart_alu_sequencer #(
    parameter int DBIT    = 8,
    parameter int OP_BIT  = 6,
    parameter int TMO     = 65535,
    parameter int TMO_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_alu_sequencer_if.slave  io_seq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TMO_BIT-1:0]  r_tmo_cnt;
    logic [DBIT-1:0]     r_alu_a;
    logic [DBIT-1:0]     r_alu_b;
    logic [OP_BIT-1:0]   r_alu_op;
    logic                r_tx_start;
    logic [DBIT-1:0]     r_tx_data;
    logic                r_busy;
    logic                r_overrun;
    logic                r_timeout;

    logic                w_rx;
    logic                w_tx_done;
    logic                w_tmo_hit;
    logic [TMO_BIT-1:0]  w_tmo_cnt_nxt;
    logic [DBIT-1:0]     w_alu_a_nxt;
    logic [DBIT-1:0]     w_alu_b_nxt;
    logic [OP_BIT-1:0]   w_alu_op_nxt;
    logic                w_tx_start_nxt;
    logic [DBIT-1:0]     w_tx_data_nxt;
    logic                w_busy_nxt;
    logic                w_overrun_nxt;
    logic                w_timeout_nxt;

    assign w_rx      = io_seq.rx_done_tick;
    assign w_tx_done = io_seq.tx_done_tick;
    assign w_tmo_hit = (r_tmo_cnt == TMO_BIT'(TMO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte arriving on the final timeout cycle is taken rather than discarded.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx) w_state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (w_rx)           w_state_nxt = S_WAIT_OP;
                else if (w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_WAIT_OP: begin
                if (w_rx)           w_state_nxt = S_EXEC;
                else if (w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_EXEC: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (w_tx_done) w_state_nxt = w_rx ? S_WAIT_B : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tmo_cnt_nxt  = '0;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_op_nxt   = r_alu_op;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_overrun_nxt  = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_busy_nxt     = (w_state_nxt == S_EXEC) || (w_state_nxt == S_SEND) ||
                         (w_state_nxt == S_WAIT_TX);
        case (r_state)
            S_IDLE: begin
                if (w_rx) w_alu_a_nxt = io_seq.rx_data;
            end
            S_WAIT_B: begin
                if (w_rx)           w_alu_b_nxt   = io_seq.rx_data;
                else if (w_tmo_hit) w_timeout_nxt = 1'b1;
                else                w_tmo_cnt_nxt = r_tmo_cnt + TMO_BIT'(1);
            end
            S_WAIT_OP: begin
                if (w_rx)           w_alu_op_nxt  = io_seq.rx_data[OP_BIT-1:0];
                else if (w_tmo_hit) w_timeout_nxt = 1'b1;
                else                w_tmo_cnt_nxt = r_tmo_cnt + TMO_BIT'(1);
            end
            S_EXEC: begin
                // The ALU has seen the new opcode for a full cycle by this edge.
                w_tx_data_nxt  = io_seq.alu_result;
                w_tx_start_nxt = 1'b1;
                w_overrun_nxt  = w_rx;
            end
            S_SEND: begin
                w_overrun_nxt = w_rx;
            end
            S_WAIT_TX: begin
                if (w_tx_done) begin
                    if (w_rx) w_alu_a_nxt = io_seq.rx_data;
                end else begin
                    w_overrun_nxt = w_rx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt  <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_op   <= w_alu_op_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_busy     <= w_busy_nxt;
            r_overrun  <= w_overrun_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign io_seq.alu_a    = r_alu_a;
    assign io_seq.alu_b    = r_alu_b;
    assign io_seq.alu_op   = r_alu_op;
    assign io_seq.tx_start = r_tx_start;
    assign io_seq.tx_data  = r_tx_data;
    assign io_seq.busy     = r_busy;
    assign io_seq.overrun  = r_overrun;
    assign io_seq.timeout  = r_timeout;

endmodule
